// File: rtl/dual_port_ram_if.sv
// Bus bundle for both ports of dual_port_ram; master drives requests,
// slave returns read data and the busy flag.
interface dual_port_ram_if #(
  parameter int WIDTH   = 32,
  parameter int WIDTHAD = 10,
  parameter int NBE     = 4
);
  logic [WIDTHAD-1:0] address_a;
  logic [WIDTHAD-1:0] address_b;
  logic               rden_a;
  logic               rden_b;
  logic               wren_a;
  logic               wren_b;
  logic [NBE-1:0]     byteena_a;
  logic [NBE-1:0]     byteena_b;
  logic [WIDTH-1:0]   data_a;
  logic [WIDTH-1:0]   data_b;
  logic [WIDTH-1:0]   q_a;
  logic [WIDTH-1:0]   q_b;
  logic               busy;

  // No backpressure: rden/wren are sampled on every rising edge; while busy=1
  // writes and address captures are dropped, never stalled or queued.
  modport master (
    output address_a, address_b, rden_a, rden_b, wren_a, wren_b,
    output byteena_a, byteena_b, data_a, data_b,
    input  q_a, q_b, busy
  );

  modport slave (
    input  address_a, address_b, rden_a, rden_b, wren_a, wren_b,
    input  byteena_a, byteena_b, data_a, data_b,
    output q_a, q_b, busy
  );
endinterface

// File: rtl/dual_port_ram.sv
// True dual-port byte-enabled RAM with registered read addresses, optional
// output registers and a zero-fill sequencer that runs after reset.
module dual_port_ram #(
  parameter int WIDTH          = 32,
  parameter int WIDTHAD        = 10,
  parameter int BYTE_W         = 8,
  parameter int OUTDATA_REG    = 0,
  parameter int RDW_NEW        = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter     INIT_FILE      = ""
) (
  input  logic           clock0,
  input  logic           aclr0_n,
  dual_port_ram_if.slave bus,
  output logic [1:0]     dbg_state_o
);
  localparam int NBE   = WIDTH / BYTE_W;
  localparam int DEPTH = 2 ** WIDTHAD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTHAD-1:0] ctr_q, ctr_d;
  logic               clr_we;
  logic               busy;
  logic               we_a, we_b, cap_a, cap_b;
  logic [WIDTHAD-1:0] addr_a_q, addr_b_q, raddr_a, raddr_b;
  logic [WIDTH-1:0]   rd_a_q, rd_b_q, rd_a_d, rd_b_d;
  logic [WIDTH-1:0]   mem [DEPTH];

  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_w,
                                                   input logic [WIDTH-1:0] new_w,
                                                   input logic [NBE-1:0]   be);
    logic [WIDTH-1:0] w;
    w = old_w;
    for (int i = 0; i < NBE; i++) begin
      if (be[i]) w[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ctr_d   = '0;
        state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        ctr_d  = ctr_q + 1'b1;
        if (ctr_q == '1) state_d = ST_READY;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q != ST_READY);
  assign dbg_state_o = state_q;
  assign bus.busy    = busy;
  assign we_a        = bus.wren_a & ~busy;
  assign we_b        = bus.wren_b & ~busy;
  assign cap_a       = bus.rden_a & ~busy;
  assign cap_b       = bus.rden_b & ~busy;

  // The read word is registered from the pre-edge array, so other-port writes
  // in the same cycle are seen as old data; only own-port RDW can bypass.
  always_comb begin
    raddr_a = cap_a ? bus.address_a : addr_a_q;
    raddr_b = cap_b ? bus.address_b : addr_b_q;
    rd_a_d  = '0;
    rd_b_d  = '0;
    if (!busy) begin
      if ((RDW_NEW != 0) && we_a && cap_a)
        rd_a_d = merge_lanes(mem[bus.address_a], bus.data_a, bus.byteena_a);
      else
        rd_a_d = mem[raddr_a];
      if ((RDW_NEW != 0) && we_b && cap_b)
        rd_b_d = merge_lanes(mem[bus.address_b], bus.data_b, bus.byteena_b);
      else
        rd_b_d = mem[raddr_b];
    end
  end

  always_ff @(posedge clock0 or negedge aclr0_n) begin
    if (!aclr0_n) begin
      state_q  <= ST_IDLE;
      ctr_q    <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      rd_a_q   <= '0;
      rd_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      addr_a_q <= raddr_a;
      addr_b_q <= raddr_b;
      rd_a_q   <= rd_a_d;
      rd_b_q   <= rd_b_d;
    end
  end

  // Array has no reset; port A is written last so it wins shared lanes.
  always_ff @(posedge clock0) begin
    if (clr_we) mem[ctr_q] <= '0;
    for (int i = 0; i < NBE; i++) begin
      if (we_b && bus.byteena_b[i])
        mem[bus.address_b][i*BYTE_W +: BYTE_W] <= bus.data_b[i*BYTE_W +: BYTE_W];
    end
    for (int i = 0; i < NBE; i++) begin
      if (we_a && bus.byteena_a[i])
        mem[bus.address_a][i*BYTE_W +: BYTE_W] <= bus.data_a[i*BYTE_W +: BYTE_W];
    end
  end

  generate
    if (OUTDATA_REG != 0) begin : g_oreg
      logic [WIDTH-1:0] out_a_q, out_b_q;
      always_ff @(posedge clock0 or negedge aclr0_n) begin
        if (!aclr0_n) begin
          out_a_q <= '0;
          out_b_q <= '0;
        end else begin
          out_a_q <= rd_a_q;
          out_b_q <= rd_b_q;
        end
      end
      assign bus.q_a = out_a_q;
      assign bus.q_b = out_b_q;
    end else begin : g_noreg
      assign bus.q_a = rd_a_q;
      assign bus.q_b = rd_b_q;
    end
  endgenerate
endmodule
